// File: rtl/zone_dimming_ctrl.sv
// zone_dimming_ctrl
//   Local-dimming zone scheduler. Reduces each ZONE_W x ZONE_H zone of the
//   incoming pixel brightness stream to its peak value. Each completed zone row
//   is committed into a ping-pong zone buffer. At every frame start the last
//   complete frame is streamed out to the LED driver.
//
// Ports
//   pixel_clk   clock for all logic
//   sys_rst     asynchronous active-low reset
//   new_frame   one-cycle frame start pulse
//   pix_vld     qualifies pix_x / pix_y / pix_lum
//   pix_x/y     pixel coordinates (11 bits)
//   pix_lum     pixel brightness (RGB max)
//   zone_valid  zone_data / zone_idx / zone_last valid
//   zone_ready  downstream accept
//   zone_data   zone peak brightness
//   zone_idx    zone number, zrow*ZONE_COLS+zcol
//   zone_last   final zone of the frame
//   busy        readout in progress
//   frame_drop  one-cycle pulse when a frame is discarded
module zone_dimming_ctrl #(
  parameter int ZONE_W    = 120,
  parameter int ZONE_H    = 120,
  parameter int ZONE_COLS = 16,
  parameter int ZONE_ROWS = 9,
  parameter int IDX_W     = 8
) (
  input  logic             pixel_clk,
  input  logic             sys_rst,
  input  logic             new_frame,
  input  logic             pix_vld,
  input  logic [10:0]      pix_x,
  input  logic [10:0]      pix_y,
  input  logic [7:0]       pix_lum,
  output logic             zone_valid,
  input  logic             zone_ready,
  output logic [7:0]       zone_data,
  output logic [IDX_W-1:0] zone_idx,
  output logic             zone_last,
  output logic             busy,
  output logic             frame_drop
);

  localparam int NZ = ZONE_COLS * ZONE_ROWS;
  localparam int AW = (NZ > 1)        ? $clog2(NZ)        : 1;
  localparam int SW = (ZONE_W > 1)    ? $clog2(ZONE_W)    : 1;
  localparam int CW = (ZONE_COLS > 1) ? $clog2(ZONE_COLS) : 1;
  localparam int LW = (ZONE_H > 1)    ? $clog2(ZONE_H)    : 1;
  localparam int DW = $clog2(ZONE_ROWS + 1);

  localparam logic [SW-1:0] SUB_LAST  = SW'(ZONE_W - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(ZONE_COLS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(ZONE_H - 1);
  localparam logic [DW-1:0] ROWS_FULL = DW'(ZONE_ROWS);
  localparam logic [AW-1:0] COLS_AW   = AW'(ZONE_COLS);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NZ - 1);
  localparam logic [AW-1:0] ADDR0     = '0;
  localparam logic [10:0]   X_END     = 11'(ZONE_COLS * ZONE_W);
  localparam logic [10:0]   X_LAST    = 11'(ZONE_COLS * ZONE_W - 1);
  localparam logic [10:0]   Y_END     = 11'(ZONE_ROWS * ZONE_H);

  typedef enum logic { W_IDLE, W_COMMIT } wstate_t;
  typedef enum logic { R_IDLE, R_SEND   } rstate_t;

  // ---------------- pixel tracking / accumulation ----------------
  logic [SW-1:0] sub_q,  cur_sub;
  logic [CW-1:0] zcol_q, cur_zcol;
  logic [LW-1:0] line_q, cur_line;
  // Zone row is tracked as its base buffer address (zrow*ZONE_COLS),
  // so the commit address needs no multiplier.
  logic [AW-1:0] base_q, cur_base, commit_base;
  logic          first_px, in_range, row_end, row_end_q;
  logic [7:0]    acc    [ZONE_COLS];
  logic [7:0]    shadow [ZONE_COLS];

  always_comb begin
    first_px = (pix_x == '0);
    in_range = (pix_x < X_END) && (pix_y < Y_END);
    cur_sub  = first_px ? '0 : sub_q;
    cur_zcol = first_px ? '0 : zcol_q;
    cur_line = line_q;
    cur_base = base_q;
    if (first_px) begin
      if (pix_y == '0) begin
        cur_line = '0;
        cur_base = '0;
      end else if (line_q == LINE_LAST) begin
        cur_line = '0;
        cur_base = base_q + COLS_AW;
      end else begin
        cur_line = line_q + 1'b1;
      end
    end
    row_end = pix_vld && in_range && (pix_x == X_LAST) && (cur_line == LINE_LAST);
  end

  always_ff @(posedge pixel_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sub_q       <= '0;
      zcol_q      <= '0;
      line_q      <= '0;
      base_q      <= '0;
      commit_base <= '0;
      row_end_q   <= 1'b0;
      for (int unsigned i = 0; i < ZONE_COLS; i++) acc[i] <= '0;
    end else begin
      row_end_q <= row_end;
      if (row_end) commit_base <= cur_base;
      if (pix_vld) begin
        if (cur_sub == SUB_LAST) begin
          sub_q  <= '0;
          zcol_q <= cur_zcol + 1'b1;
        end else begin
          sub_q  <= cur_sub + 1'b1;
          zcol_q <= cur_zcol;
        end
        line_q <= cur_line;
        base_q <= cur_base;
        if (in_range) begin
          if ((cur_line == '0) || (pix_lum > acc[cur_zcol]))
            acc[cur_zcol] <= pix_lum;
        end
      end
    end
  end

  // ---------------- commit, frame swap, readout ----------------
  wstate_t       wstate;
  rstate_t       rstate;
  logic [CW-1:0] wcnt;
  logic [AW-1:0] waddr;
  logic [AW-1:0] ridx;
  logic [DW-1:0] rows_done;
  logic          wbank, rbank, swap_pend;
  logic          decide, do_swap;
  logic [7:0]    mem [2][NZ];

  // A frame start seen while a row is being snapped or committed waits
  // until the commit has finished so rows_done is final.
  always_comb begin
    decide  = (new_frame || swap_pend) && (wstate == W_IDLE) && !row_end_q;
    do_swap = decide && (rows_done == ROWS_FULL) && (rstate == R_IDLE);
  end

  assign zone_idx = IDX_W'(ridx);

  always_ff @(posedge pixel_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wstate     <= W_IDLE;
      rstate     <= R_IDLE;
      wcnt       <= '0;
      waddr      <= '0;
      ridx       <= '0;
      rows_done  <= '0;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      swap_pend  <= 1'b0;
      zone_valid <= 1'b0;
      zone_data  <= '0;
      zone_last  <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
      for (int unsigned i = 0; i < ZONE_COLS; i++) shadow[i] <= '0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned a = 0; a < NZ; a++) mem[b][a] <= '0;
    end else begin
      frame_drop <= 1'b0;

      case (wstate)
        W_IDLE: begin
          if (row_end_q) begin
            shadow <= acc;
            waddr  <= commit_base;
            wcnt   <= '0;
            wstate <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          mem[wbank][waddr] <= shadow[wcnt];
          waddr <= waddr + 1'b1;
          wcnt  <= wcnt + 1'b1;
          if (wcnt == COL_LAST) begin
            wstate    <= W_IDLE;
            rows_done <= rows_done + 1'b1;
          end
        end
      endcase

      if (decide) begin
        swap_pend <= 1'b0;
        rows_done <= '0;
        if (do_swap) begin
          rbank <= wbank;
          wbank <= ~wbank;
        end else begin
          frame_drop <= 1'b1;
        end
      end else if (new_frame) begin
        swap_pend <= 1'b1;
      end

      case (rstate)
        R_IDLE: begin
          if (do_swap) begin
            rstate     <= R_SEND;
            zone_valid <= 1'b1;
            busy       <= 1'b1;
            ridx       <= ADDR0;
            zone_data  <= mem[wbank][ADDR0];
            zone_last  <= (IDX_LAST == ADDR0);
          end
        end
        R_SEND: begin
          if (zone_ready) begin
            if (zone_last) begin
              rstate     <= R_IDLE;
              zone_valid <= 1'b0;
              busy       <= 1'b0;
              zone_last  <= 1'b0;
            end else begin
              ridx      <= ridx + 1'b1;
              zone_data <= mem[rbank][ridx + 1'b1];
              zone_last <= ((ridx + 1'b1) == IDX_LAST);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zone_dimming_ctrl.sv
// Testbench for zone_dimming_ctrl with a 2x2 grid of 4x2-pixel zones
// (8x4 active). Expected zone beats are queued when a frame start is issued;
// a monitor compares every accepted beat and checks values held while stalled.
module tb_zone_dimming_ctrl;

  logic        pixel_clk = 1'b0;
  logic        sys_rst   = 1'b0;
  logic        new_frame = 1'b0;
  logic        pix_vld   = 1'b0;
  logic [10:0] pix_x     = '0;
  logic [10:0] pix_y     = '0;
  logic [7:0]  pix_lum   = '0;
  logic        zone_ready = 1'b0;
  logic        zone_valid;
  logic [7:0]  zone_data;
  logic [7:0]  zone_idx;
  logic        zone_last;
  logic        busy;
  logic        frame_drop;

  always #5 pixel_clk = ~pixel_clk;

  zone_dimming_ctrl #(
    .ZONE_W(4), .ZONE_H(2), .ZONE_COLS(2), .ZONE_ROWS(2), .IDX_W(8)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .new_frame (new_frame),
    .pix_vld   (pix_vld),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_lum   (pix_lum),
    .zone_valid(zone_valid),
    .zone_ready(zone_ready),
    .zone_data (zone_data),
    .zone_idx  (zone_idx),
    .zone_last (zone_last),
    .busy      (busy),
    .frame_drop(frame_drop)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] idx;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   drop_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Zone z of a frame built with base b peaks at b + 10*z + 1.
  task automatic push_frame(input int base);
    for (int z = 0; z < 4; z++)
      sb.push_back('{data: 8'(base + 10*z + 1), idx: 8'(z), last: (z == 3)});
  endtask

  function automatic logic [7:0] lum_of(input int base, input int x, input int y);
    if (x >= 8 || y >= 4) return 8'hFF;
    return 8'(base + 10*((y/2)*2 + x/4) + y%2);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pixel_clk);
      #1;
    end
  endtask

  task automatic send_frame(input int base, input int nlines, input bit oor);
    int xmax;
    xmax = oor ? 12 : 8;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < xmax; x++) begin
        @(posedge pixel_clk);
        #1;
        pix_vld = 1'b1;
        pix_x   = 11'(x);
        pix_y   = 11'(y);
        pix_lum = lum_of(base, x, y);
      end
    end
    @(posedge pixel_clk);
    #1;
    pix_vld = 1'b0;
  endtask

  task automatic pulse_nf();
    new_frame = 1'b1;
    tick(1);
    new_frame = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick(1);
      n++;
    end
    check(name, busy, 0);
  endtask

  // Monitor: compares accepted beats against the queue and checks that a
  // stalled beat is presented unchanged on the following cycle.
  exp_t       e;
  logic       h_vld = 1'b0;
  logic [7:0] h_data, h_idx;
  logic       h_last;

  always @(negedge pixel_clk) begin
    if (!sys_rst) begin
      h_vld = 1'b0;
    end else begin
      if (frame_drop) drop_cnt++;
      if (zone_valid) begin
        if (h_vld) begin
          check("hold_data", zone_data, h_data);
          check("hold_idx",  zone_idx,  h_idx);
          check("hold_last", zone_last, h_last);
        end
        if (zone_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got idx %0d data %0d, expected no beat", zone_idx, zone_data);
          end else begin
            e = sb.pop_front();
            check("zone_data", zone_data, e.data);
            check("zone_idx",  zone_idx,  e.idx);
            check("zone_last", zone_last, e.last);
          end
        end
      end
      h_vld  = zone_valid && !zone_ready;
      h_data = zone_data;
      h_idx  = zone_idx;
      h_last = zone_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(3);
    sys_rst = 1'b1;
    check("rst_valid", zone_valid, 0);
    check("rst_busy",  busy,       0);
    check("rst_drop",  frame_drop, 0);
    check("rst_data",  zone_data,  0);
    check("rst_idx",   zone_idx,   0);
    check("rst_last",  zone_last,  0);

    // Frame A, free-flowing readout
    zone_ready = 1'b1;
    send_frame(0, 4, 0);
    tick(6);
    push_frame(0);
    pulse_nf();
    check("valid_after_nf", zone_valid, 1);
    check("busy_in_send",   busy,       1);
    check("first_idx",      zone_idx,   0);
    wait_idle("readout_a_done");
    check("sb_drained_a", sb.size(), 0);

    // Same frame, frame start right after the last pixel, ready toggling
    begin
      bit pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      send_frame(0, 4, 0);
      push_frame(0);
      pulse_nf();
      for (int k = 0; k < 40; k++) begin
        zone_ready = pat[k % 4];
        tick(1);
      end
      zone_ready = 1'b1;
      check("toggle_done",      busy,      0);
      check("sb_drained_toggle", sb.size(), 0);
      check("no_drop_toggle",   drop_cnt,  0);
    end

    // Incomplete frame is dropped, then a full frame reads out normally
    send_frame(0, 2, 0);
    tick(6);
    pulse_nf();
    tick(4);
    check("drop_partial",   drop_cnt,   1);
    check("busy_partial",   busy,       0);
    check("valid_partial",  zone_valid, 0);
    send_frame(50, 4, 0);
    tick(6);
    push_frame(50);
    pulse_nf();
    wait_idle("readout_b_done");
    check("drop_after_b", drop_cnt, 1);

    // Readout stalled while the next frame completes
    send_frame(0, 4, 0);
    tick(6);
    zone_ready = 1'b0;
    push_frame(0);
    pulse_nf();
    check("stall_valid", zone_valid, 1);
    send_frame(70, 4, 0);
    tick(6);
    pulse_nf();
    tick(3);
    check("drop_busy",        drop_cnt,   2);
    check("stall_still_valid", zone_valid, 1);
    check("stall_idx",        zone_idx,   0);
    zone_ready = 1'b1;
    wait_idle("readout_stall_done");
    check("sb_drained_stall", sb.size(), 0);

    // Out-of-range pixels (x=8..11, y=4) at full brightness are ignored
    send_frame(0, 5, 1);
    tick(6);
    push_frame(0);
    pulse_nf();
    wait_idle("readout_oor_done");
    check("drop_oor", drop_cnt, 2);

    // Reset in the middle of a readout
    send_frame(0, 4, 0);
    tick(6);
    zone_ready = 1'b0;
    push_frame(0);
    pulse_nf();
    tick(3);
    check("pre_rst_valid", zone_valid, 1);
    sys_rst = 1'b0;
    sb.delete();
    tick(1);
    sys_rst = 1'b1;
    check("post_rst_valid", zone_valid, 0);
    check("post_rst_busy",  busy,       0);
    zone_ready = 1'b1;
    send_frame(0, 2, 0);
    tick(6);
    pulse_nf();
    tick(4);
    check("drop_after_rst", drop_cnt, 3);
    check("busy_after_rst", busy,     0);

    tick(2);
    check("sb_final_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
